mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester controller for the shared single-port 1024x10 RAM (20-bit
//  paired-word inout bus, mem_ready write handshake). Port 0 = instruction
//  fetch, port 1 = data load/store. Round-robin grant, owns mem_we,
//  mem_addr and the bus tri-state, sequences the 2-phase write, returns words.
// PARAMETERS
//  ADDR_W      10  RAM word-address width
//  WORD_W      10  RAM word width; bus is 2*WORD_W
//  WR_TIMEOUT  8   max cycles per write handshake phase before error
// PORTS
//  clk          in     1        single clock, all state on posedge
//  rst_n        in     1        asynchronous active-low reset
//  reqN_valid   in     1        N=0,1: request pending
//  reqN_we      in     1        1=write, 0=read
//  reqN_addr    in     ADDR_W   word address
//  reqN_wdata   in     WORD_W   write word
//  reqN_ready   out    1        1-cycle pulse: request accepted
//  reqN_done    out    1        1-cycle pulse: access complete
//  reqN_rdata   out    WORD_W   read word, valid with reqN_done on reads
//  reqN_err     out    1        1-cycle pulse with reqN_done on write timeout
//  mem_we       out    1        RAM write enable
//  mem_addr     out    ADDR_W   RAM address
//  mem_data     inout  2*WORD_W driven only while mem_we=1, else 'z
//  mem_ready    in     1        RAM handshake
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, rr_last=1 (port 0 wins first tie),
//   mem_we=0, mem_addr=0, mem_data='z, all ready/done/err=0, rdata=0,
//   timeout counter=0. Mid-access reset aborts; no done pulse issued.
//  FSM: IDLE, RD, WR_LO, WR_HI, RESP.
//  IDLE: if any valid, grant per round-robin (both valid -> port !rr_last;
//   one valid -> that port); latch we/addr/wdata, pulse reqN_ready, set
//   rr_last=granted port. Read -> RD; write -> WR_LO.
//  RD: mem_we=0, mem_addr=latched addr. RAM read is combinational; at the
//   posedge capture rdata = addr[0] ? mem_data[19:10] : mem_data[9:0] -> RESP.
//   Read latency: accept edge +2 edges to done pulse.
//  WR_LO: mem_we=1, mem_data={wdata,wdata} (RAM picks half by addr[0]).
//   Wait for mem_ready=0 sampled -> WR_HI.
//  WR_HI: hold we/addr/data; wait mem_ready=1 sampled -> RESP (write done).
//  Timeout: counter clears on phase entry, +1 per cycle in WR_LO/WR_HI;
//   reaching WR_TIMEOUT -> RESP with err=1; mem_we drops next cycle.
//  RESP: pulse reqN_done (+rdata/err) for granted port, mem_we=0 -> IDLE.
//   Requests cannot be accepted in RESP; one access in flight, max.
//  Requester must hold valid/we/addr/wdata until its ready pulse; deassert
//   before ready = request withdrawn, no side effects.
//  Back-to-back same port: accepted from IDLE the cycle after RESP; if the
//   other port was also waiting it wins (fairness).
//  Address wrap: no arithmetic on addresses; 10'h3FF legal (odd half).
//  mem_data must never be driven while mem_we=0 (no bus contention).
// STRUCTURE
//  Package mem_arb_pkg: ADDR_W/WORD_W localparams, state enum
//   {IDLE,RD,WR_LO,WR_HI,RESP}, port index typedef.
//  Sub-module mem_arb_rr: 2-way round-robin picker (valid[1:0], rr_last ->
//   grant, grant_idx); purely combinational, pointer held in parent.
//  Parent holds FSM, request latch, timeout counter, tri-state driver.
// TESTING (bench instantiates the 1024x10 RAM, preloaded ram[10]=5, ram[11]=3)
//  Port0 read addr 10 -> ready pulse, done 2 edges later, rdata0=10'd5.
//  Port1 read addr 11 -> rdata1=10'd3; mem_data never driven by arbiter.
//  Port1 write 10'd7 to addr 12 -> mem_we high through WR_LO/WR_HI,
//   done1 with err1=0; subsequent port0 read addr 12 -> rdata0=10'd7.
//  Both valid every cycle, 6 accesses -> grants alternate 0,1,0,1,0,1.
//  Stub mem_ready stuck 1 on write, WR_TIMEOUT=8 -> err pulse + done after
//   8 cycles in WR_LO, mem_we low next cycle, FSM back in IDLE.
//  Assert rst_n=0 in WR_HI -> mem_we=0 and mem_data='z immediately,
//   no done pulse; after release first tie goes to port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port RAM arbiter: bus widths, FSM states, port index.
// Pure declarations, no logic.
package mem_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int WORD_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef logic port_idx_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle: valid/we/addr/wdata in, ready/done/rdata/err out.
// The requester holds its request until ready; done arrives later.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (output valid, we, addr, wdata, input ready, done, rdata, err);
  modport slave  (input valid, we, addr, wdata, output ready, done, rdata, err);
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker, combinational; on a tie the port not granted last wins.
// No state here: the last-grant pointer lives in the parent.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  port_idx_t  rr_last_i,
  output logic [1:0] grant_o,
  output port_idx_t  grant_idx_o
);
  always_comb begin
    grant_idx_o = (valid_i == 2'b11) ? ~rr_last_i : valid_i[1];
    grant_o     = 2'b00;
    if (valid_i != 2'b00) grant_o[grant_idx_o] = 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch/data ports onto the shared paired-word RAM; reads done 2 edges after accept,
// writes after the mem_ready low/high handshake (or timeout). One access in flight; others wait.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WR_TIMEOUT = 8
)
(
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   req0,
  mem_port_arbiter_if.slave   req1,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  inout  wire  [2*WORD_W-1:0] mem_data,
  input  logic                mem_ready
);
  localparam int CNT_W = $clog2(WR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(WR_TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  port_idx_t         gnt_q, rr_last_q, gnt_idx;
  logic [1:0]        req_vld, gnt_vec;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [WORD_W-1:0] wdata_q, sel_wdata, rdata_q;
  logic              err_q, sel_we, tmo;

  assign req_vld   = {req1.valid, req0.valid};
  assign sel_we    = gnt_idx ? req1.we    : req0.we;
  assign sel_addr  = gnt_idx ? req1.addr  : req0.addr;
  assign sel_wdata = gnt_idx ? req1.wdata : req0.wdata;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  mem_arb_rr u_rr (
    .valid_i     (req_vld),
    .rr_last_i   (rr_last_q),
    .grant_o     (gnt_vec),
    .grant_idx_o (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter restarts on every phase entry, so each handshake phase gets its own budget.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req_vld) state_d = sel_we ? WR_LO : RD;
      end
      RD: state_d = RESP;
      WR_LO: begin
        if (!mem_ready) begin
          state_d = WR_HI;
          cnt_d   = '0;
        end else if (cnt_inc == TMO) begin
          state_d = RESP;
          tmo     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR_HI: begin
        if (mem_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end else if (cnt_inc == TMO) begin
          state_d = RESP;
          tmo     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we     = (state_q == WR_LO) || (state_q == WR_HI);
    req0.ready = (state_q == IDLE) && gnt_vec[0];
    req1.ready = (state_q == IDLE) && gnt_vec[1];
    req0.done  = (state_q == RESP) && (gnt_q == 1'b0);
    req1.done  = (state_q == RESP) && (gnt_q == 1'b1);
    req0.err   = req0.done && err_q;
    req1.err   = req1.done && err_q;
    req0.rdata = rdata_q;
    req1.rdata = rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && |req_vld) begin
        gnt_q     <= gnt_idx;
        rr_last_q <= gnt_idx;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        err_q     <= 1'b0;
      end
      if (state_q == RD)
        rdata_q <= addr_q[0] ? mem_data[2*WORD_W-1:WORD_W] : mem_data[WORD_W-1:0];
      if (tmo) err_q <= 1'b1;
    end
  end

  // The RAM owns the bus whenever we are not writing.
  assign mem_addr = addr_q;
  assign mem_data = mem_we ? {wdata_q, wdata_q} : 'z;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural paired-word RAM, per-port expectation queues,
// and a negedge monitor that scores every ready/done the arbiter presents.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int WR_TIMEOUT = 8;

  typedef struct packed {
    logic       is_rd;
    logic [9:0] rdata;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if req0_if();
  mem_port_arbiter_if req1_if();

  logic        mem_we;
  logic [9:0]  mem_addr;
  wire  [19:0] mem_data;
  logic        mem_ready = 1'b1;

  mem_port_arbiter #(.WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0_if),
    .req1      (req1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready)
  );

  logic [9:0] ram [1024];
  logic [9:0] mem_model [1024];
  exp_t q0[$];
  exp_t q1[$];
  int   gq[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic stuck = 1'b0;
  int   ph = 0;
  int   lat = 0;

  assign mem_data = mem_we ? 'z : {ram[{mem_addr[9:1], 1'b1}], ram[{mem_addr[9:1], 1'b0}]};

  // RAM side of the write handshake: drop ready after a delay, then store and raise it.
  always @(negedge clk) begin
    if (!mem_we) begin
      ph = 0;
      mem_ready = 1'b1;
      lat = $urandom_range(0, 2);
    end else if (stuck) begin
      mem_ready = 1'b1;
    end else if (ph == 0) begin
      if (lat == 0) begin
        mem_ready = 1'b0;
        ph = 1;
        lat = $urandom_range(0, 3);
      end else lat--;
    end else if (ph == 1) begin
      if (lat == 0) begin
        ram[mem_addr] = mem_addr[0] ? mem_data[19:10] : mem_data[9:0];
        mem_ready = 1'b1;
        ph = 2;
      end else lat--;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic logic rdy_of(input int p);
    return (p == 0) ? req0_if.ready : req1_if.ready;
  endfunction

  // Monitor: latency and data expectations come from the access rules, not the FSM.
  int         cyc = 0;
  int         rdy_cyc [2];
  int         we_cnt = 0;
  logic [1:0] rdy, dn, er;
  logic [9:0] rd [2];
  always @(negedge clk) begin
    exp_t e;
    int   l;
    logic have;
    cyc++;
    if (rst_n) begin
      rdy = {req1_if.ready, req0_if.ready};
      dn  = {req1_if.done, req0_if.done};
      er  = {req1_if.err, req0_if.err};
      rd[0] = req0_if.rdata;
      rd[1] = req1_if.rdata;
      for (int p = 0; p < 2; p++) begin
        if (rdy[p]) begin
          rdy_cyc[p] = cyc;
          we_cnt = 0;
          if (gq.size() > 0) chk("grant_order", p, gq.pop_front());
        end
      end
      if (mem_we) we_cnt++;
      for (int p = 0; p < 2; p++) begin
        if (er[p]) chk("err_needs_done", int'(dn[p]), 1);
        if (dn[p]) begin
          have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (!have) chk("done_unexpected", int'(dn[p]), 0);
          else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            l = cyc - rdy_cyc[p];
            chk("err", int'(er[p]), int'(e.err));
            if (e.is_rd) begin
              chk("rdata", int'(rd[p]), int'(e.rdata));
              chk("read_latency", l, 2);
            end else begin
              chk("we_high_cycles", we_cnt, l - 1);
              if (e.err) begin
                chk("timeout_latency", l, WR_TIMEOUT + 1);
                chk("we_low_at_err", int'(mem_we), 0);
              end
            end
          end
        end
      end
    end
  end

  // Pushes the expectation, presents the request, returns one step after the accept edge.
  task automatic issue(input int p, input logic we, input logic [9:0] addr,
                       input logic [9:0] wd, input logic exp_err, input logic upd);
    exp_t e;
    int   t;
    e.is_rd = !we;
    e.rdata = mem_model[addr];
    e.err   = exp_err;
    if (we && upd) mem_model[addr] = wd;
    if (p == 0) begin
      q0.push_back(e);
      req0_if.valid = 1'b1; req0_if.we = we; req0_if.addr = addr; req0_if.wdata = wd;
    end else begin
      q1.push_back(e);
      req1_if.valid = 1'b1; req1_if.we = we; req1_if.addr = addr; req1_if.wdata = wd;
    end
    t = 0;
    @(negedge clk);
    while (!rdy_of(p) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("ready_wait");
    @(posedge clk);
    #1;
    if (p == 0) req0_if.valid = 1'b0;
    else        req1_if.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail("done_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"}, int'(mem_we), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_done0"}, int'(req0_if.done), 0);
    chk({tag, "_done1"}, int'(req1_if.done), 0);
    chk({tag, "_err0"}, int'(req0_if.err), 0);
    chk({tag, "_rdata0"}, int'(req0_if.rdata), 0);
    chk({tag, "_rdata1"}, int'(req1_if.rdata), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 10'($urandom_range(0, 1023));
      mem_model[i] = ram[i];
    end
    ram[10] = 10'd5; mem_model[10] = 10'd5;
    ram[11] = 10'd3; mem_model[11] = 10'd3;
    req0_if.valid = 1'b0; req0_if.we = 1'b0; req0_if.addr = '0; req0_if.wdata = '0;
    req1_if.valid = 1'b0; req1_if.we = 1'b0; req1_if.addr = '0; req1_if.wdata = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_ready0", int'(req0_if.ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 1'b0, 10'd10, 10'd0, 1'b0, 1'b0);
    wait_drain();
    issue(1, 1'b0, 10'd11, 10'd0, 1'b0, 1'b0);
    wait_drain();

    // Port 1 write; a one-cycle port 0 request during it is withdrawn and must vanish.
    issue(1, 1'b1, 10'd12, 10'd7, 1'b0, 1'b1);
    req0_if.valid = 1'b1; req0_if.we = 1'b0; req0_if.addr = 10'd30;
    @(posedge clk);
    #1;
    req0_if.valid = 1'b0;
    wait_drain();
    issue(0, 1'b0, 10'd12, 10'd0, 1'b0, 1'b0);
    wait_drain();

    stuck = 1'b1;
    issue(0, 1'b1, 10'd20, 10'd9, 1'b1, 1'b0);
    wait_drain();
    stuck = 1'b0;
    issue(0, 1'b0, 10'd20, 10'd0, 1'b0, 1'b0);
    wait_drain();
    issue(1, 1'b0, 10'h3FF, 10'd0, 1'b0, 1'b0);
    wait_drain();

    // Reset while the second write phase is in progress.
    issue(1, 1'b1, 10'd600, 10'd1, 1'b0, 1'b0);
    t = 0;
    @(negedge clk);
    while (mem_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("mem_ready_low_wait");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) gq.push_back(i % 2);
    fork
      for (int i = 0; i < 3; i++) issue(0, 1'b0, 10'($urandom_range(0, 511)), 10'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) issue(1, 1'b0, 10'($urandom_range(512, 1023)), 10'd0, 1'b0, 1'b0);
    join
    wait_drain();
    chk("grants_left", gq.size(), 0);

    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 511)),
              10'($urandom_range(0, 1023)), 1'b0, 1'b1);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        issue(1, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(512, 1022)),
              10'($urandom_range(0, 1023)), 1'b0, 1'b1);
      end
    join
    wait_drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
